// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared opcode, ALU code and sequencer state definitions
package cpu_defs;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // ALU codes share the R-type funct encoding so R instructions pass straight through
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_SLT = 6'b101010;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J
    } iclass_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - control/strobe bundle between sequencer and datapath
interface instr_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step_req;
    logic [5:0]       op_control;
    logic [5:0]       funct_control;
    logic             zero;
    logic             store;
    logic             w_reg;
    logic             w_data;
    logic [5:0]       op_alu;
    logic             busy;
    logic             step_ack;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output run, step_req, op_control, funct_control, zero,
        input  store, w_reg, w_data, op_alu, busy, step_ack, halted, instr_count
    );

    modport slave (
        input  run, step_req, op_control, funct_control, zero,
        output store, w_reg, w_data, op_alu, busy, step_ack, halted, instr_count
    );
endinterface

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - opcode/funct to ALU operation, instruction class and legality
module alu_decode
    import cpu_defs::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [5:0] alu,
    output logic       alu_upd,
    output logic       legal,
    output iclass_t    cls
);
    always_comb begin
        alu     = ALU_ADD;
        alu_upd = 1'b1;
        legal   = 1'b1;
        cls     = C_R;
        case (op)
            OP_R:    alu = funct;
            OP_ADDI: cls = C_ADDI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ: begin
                alu = ALU_SUB;
                cls = C_BEQ;
            end
            // J leaves the previous ALU operation in place
            OP_J: begin
                alu_upd = 1'b0;
                cls     = C_J;
            end
            default: begin
                alu_upd = 1'b0;
                legal   = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
// with run/single-step control, retire counter and halt on illegal opcode.
module instr_sequencer
    import cpu_defs::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32
) (
    input logic               clk,
    input logic               rst,
    instr_sequencer_if.slave  bus
);
    localparam int MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [MW-1:0] MEM_LAST = MW'(MEM_LAT - 1);

    state_t           state_q, state_d;
    iclass_t          cls_q, cls_d;
    logic [MW-1:0]    cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             store_q, store_d;
    logic             w_reg_q, w_reg_d;
    logic             w_data_q, w_data_d;
    logic [5:0]       op_alu_q, op_alu_d;
    logic             busy_q, busy_d;
    logic             step_ack_q, step_ack_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [5:0] dec_alu;
    logic       dec_alu_upd, dec_legal;
    iclass_t    dec_cls;
    logic       mem_done_d, retire_d;
    logic       unused_zero;

    assign unused_zero = bus.zero;

    alu_decode u_alu_decode (
        .op      (bus.op_control),
        .funct   (bus.funct_control),
        .alu     (dec_alu),
        .alu_upd (dec_alu_upd),
        .legal   (dec_legal),
        .cls     (dec_cls)
    );

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        op_alu_d = op_alu_q;
        // store_q marks the retire cycle of every instruction class
        if (store_q) begin
            step_d  = 1'b0;
            state_d = (!step_q && bus.run) ? S_FETCH : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_d = S_FETCH;
                    end else if (bus.step_req) begin
                        state_d = S_FETCH;
                        step_d  = 1'b1;
                    end
                end
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    cls_d = dec_cls;
                    if (dec_alu_upd) op_alu_d = dec_alu;
                    state_d = dec_legal ? S_EXEC : S_HALT;
                end
                S_EXEC: begin
                    cnt_d   = '0;
                    state_d = (cls_q == C_LW || cls_q == C_SW) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (cnt_q == MEM_LAST) state_d = S_WB;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they line up with it once registered
        mem_done_d = (state_d == S_MEM) && (cnt_d == MEM_LAST);
        retire_d   = ((state_d == S_EXEC) && (cls_d == C_BEQ || cls_d == C_J))
                   || (mem_done_d && cls_d == C_SW)
                   || (state_d == S_WB);
        store_d    = retire_d;
        w_reg_d    = (state_d == S_WB);
        w_data_d   = mem_done_d && (cls_d == C_SW);
        step_ack_d = retire_d && step_d;
        count_d    = count_q + CNT_W'(retire_d);
        busy_d     = !(state_d == S_IDLE || state_d == S_HALT);
        halted_d   = halted_q || (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cls_q      <= C_R;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            store_q    <= 1'b0;
            w_reg_q    <= 1'b0;
            w_data_q   <= 1'b0;
            op_alu_q   <= '0;
            busy_q     <= 1'b0;
            step_ack_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            store_q    <= store_d;
            w_reg_q    <= w_reg_d;
            w_data_q   <= w_data_d;
            op_alu_q   <= op_alu_d;
            busy_q     <= busy_d;
            step_ack_q <= step_ack_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign bus.store       = store_q;
    assign bus.w_reg       = w_reg_q;
    assign bus.w_data      = w_data_q;
    assign bus.op_alu      = op_alu_q;
    assign bus.busy        = busy_q;
    assign bus.step_ack    = step_ack_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = count_q;
endmodule
